// File: rtl/hard_act_pkg.sv
// Shared mode encodings and fixed-point constant derivation for the hard activation pipeline.
package hard_act_pkg;

    typedef enum logic [1:0] {
        MODE_RELU   = 2'd0,
        MODE_RELU6  = 2'd1,
        MODE_HSIG   = 2'd2,
        MODE_HSWISH = 2'd3
    } act_mode_e;

    function automatic int data_width_of(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int in_width_of(input int int_bits, input int frac_bits);
        return 2 * (int_bits + frac_bits) - frac_bits + 6;
    endfunction

    function automatic int one_of(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    function automatic int three_of(input int frac_bits);
        return 3 * one_of(frac_bits);
    endfunction

    function automatic int six_of(input int frac_bits);
        return 6 * one_of(frac_bits);
    endfunction

    // round(ONE/6) with ties rounded up
    function automatic int c6_of(input int frac_bits);
        return (one_of(frac_bits) + 3) / 6;
    endfunction

    function automatic int maxv_of(input int data_width);
        return (1 << (data_width - 1)) - 1;
    endfunction

    function automatic int minv_of(input int data_width);
        return -(1 << (data_width - 1));
    endfunction

endpackage

// File: rtl/hard_act_if.sv
// Valid/ready stream bundle for hard_act_pipe: accumulator beats in, activated beats out.
interface hard_act_if #(
    parameter int INT_BITS  = 5,
    parameter int FRAC_BITS = 9,
    parameter int LANES     = 4
);
    localparam int DATA_WIDTH = INT_BITS + FRAC_BITS;
    localparam int IN_WIDTH   = 2 * DATA_WIDTH - FRAC_BITS + 6;

    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*IN_WIDTH-1:0]   in_data;
    logic [1:0]                  in_mode;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic                        out_last;

    modport master (
        output in_valid, in_data, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/hard_act_lane.sv
// One channel of the 3-stage activation datapath: clamp/offset, C6 multiply, xs*hsig and mode select.
module hard_act_lane
    import hard_act_pkg::*;
#(
    parameter int INT_BITS  = 5,
    parameter int FRAC_BITS = 9,
    localparam int DW       = INT_BITS + FRAC_BITS,
    localparam int IW       = 2 * DW - FRAC_BITS + 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    input  logic signed [IW-1:0] x,
    input  act_mode_e            mode,
    output logic signed [DW-1:0] y,
    output logic                 sat
);
    localparam int OW = FRAC_BITS + 3;
    localparam int PW = OW + FRAC_BITS;
    localparam int W2 = 2 * DW;

    localparam logic signed [IW-1:0] MAXV_X   = IW'(maxv_of(DW));
    localparam logic signed [IW-1:0] MINV_X   = IW'(minv_of(DW));
    localparam logic signed [IW-1:0] THREE_X  = IW'(three_of(FRAC_BITS));
    localparam logic signed [IW-1:0] NTHREE_X = IW'(-three_of(FRAC_BITS));
    localparam logic signed [IW-1:0] SIX_X    = IW'(six_of(FRAC_BITS));
    localparam logic signed [DW-1:0] MAXV_D   = DW'(maxv_of(DW));
    localparam logic signed [DW-1:0] MINV_D   = DW'(minv_of(DW));
    localparam logic signed [DW-1:0] SIX_D    = DW'(six_of(FRAC_BITS));
    localparam logic signed [DW-1:0] ONE_D    = DW'(one_of(FRAC_BITS));
    localparam logic [PW-1:0]        C6_P     = PW'(c6_of(FRAC_BITS));

    logic signed [IW-1:0] sum_c;
    logic signed [DW-1:0] xs_c, relu_c, relu6_c;
    logic [OW-1:0]        off_c;
    logic                 lo_c, hi_c, sat_c;

    act_mode_e            mode1, mode2;
    logic signed [DW-1:0] xs1, relu1, relu61, xs2, relu2, relu62, hsig2;
    logic [OW-1:0]        off1;
    logic                 lo1, hi1, sat1, lo2, hi2, sat2;

    logic [PW-1:0]        prod2_c;
    logic signed [DW-1:0] hsig_c;
    logic signed [W2-1:0] prod3_c;
    logic signed [DW-1:0] hswish_c, y_c;

    always_comb begin
        sum_c = x + THREE_X;
        off_c = sum_c[OW-1:0];
        lo_c  = (x <= NTHREE_X);
        hi_c  = (x >= THREE_X);
        if (x > MAXV_X)      xs_c = MAXV_D;
        else if (x < MINV_X) xs_c = MINV_D;
        else                 xs_c = x[DW-1:0];
        relu_c = (x < 0) ? '0 : xs_c;
        if (x < 0)          relu6_c = '0;
        else if (x > SIX_X) relu6_c = SIX_D;
        else                relu6_c = x[DW-1:0];
        // Only clamps that change the selected result count; the ReLU zero floor does not.
        case (mode)
            MODE_RELU:   sat_c = (x > MAXV_X);
            MODE_RELU6:  sat_c = (x > SIX_X);
            MODE_HSWISH: sat_c = (x > MAXV_X) || (x < MINV_X);
            default:     sat_c = 1'b0;
        endcase
    end

    always_comb begin
        prod2_c = PW'(off1) * C6_P;
        if (lo1)      hsig_c = '0;
        else if (hi1) hsig_c = ONE_D;
        else          hsig_c = DW'(prod2_c >> FRAC_BITS);
    end

    always_comb begin
        prod3_c = W2'(xs2) * W2'(hsig2);
        if (lo2)      hswish_c = '0;
        else if (hi2) hswish_c = xs2;
        else          hswish_c = DW'(prod3_c >>> FRAC_BITS);
        case (mode2)
            MODE_RELU:  y_c = relu2;
            MODE_RELU6: y_c = relu62;
            MODE_HSIG:  y_c = hsig2;
            default:    y_c = hswish_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode1  <= MODE_RELU;
            xs1    <= '0;
            relu1  <= '0;
            relu61 <= '0;
            off1   <= '0;
            lo1    <= 1'b0;
            hi1    <= 1'b0;
            sat1   <= 1'b0;
            mode2  <= MODE_RELU;
            xs2    <= '0;
            relu2  <= '0;
            relu62 <= '0;
            hsig2  <= '0;
            lo2    <= 1'b0;
            hi2    <= 1'b0;
            sat2   <= 1'b0;
            y      <= '0;
            sat    <= 1'b0;
        end else if (adv) begin
            mode1  <= mode;
            xs1    <= xs_c;
            relu1  <= relu_c;
            relu61 <= relu6_c;
            off1   <= off_c;
            lo1    <= lo_c;
            hi1    <= hi_c;
            sat1   <= sat_c;
            mode2  <= mode1;
            xs2    <= xs1;
            relu2  <= relu1;
            relu62 <= relu61;
            hsig2  <= hsig_c;
            lo2    <= lo1;
            hi2    <= hi1;
            sat2   <= sat1;
            y      <= y_c;
            sat    <= sat2;
        end
    end
endmodule

// File: rtl/hard_act_pipe.sv
// LANES-wide hard activation pipeline (ReLU/ReLU6/hsig/hswish), 3-cycle latency, global stall.
// Saturation counter is built only when HARD_ACT_SAT_CNT_EN is defined; otherwise sat_cnt reads 0.
module hard_act_pipe
    import hard_act_pkg::*;
#(
    parameter int INT_BITS  = 5,
    parameter int FRAC_BITS = 9,
    parameter int LANES     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    hard_act_if.slave   bus,
    input  logic        sat_clr,
    output logic [15:0] sat_cnt
);
    localparam int DATA_WIDTH = INT_BITS + FRAC_BITS;
    localparam int IN_WIDTH   = 2 * DATA_WIDTH - FRAC_BITS + 6;

    logic                        adv;
    logic                        v1, v2, out_valid_q;
    logic                        l1, l2, out_last_q;
    logic signed [DATA_WIDTH-1:0] lane_y [LANES];
    logic [LANES-1:0]            lane_sat;
    logic [LANES*DATA_WIDTH-1:0] out_data_c;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_c;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        hard_act_lane #(
            .INT_BITS  (INT_BITS),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .x     (bus.in_data[i*IN_WIDTH +: IN_WIDTH]),
            .mode  (act_mode_e'(bus.in_mode)),
            .y     (lane_y[i]),
            .sat   (lane_sat[i])
        );
    end

    always_comb begin
        out_data_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            out_data_c[i*DATA_WIDTH +: DATA_WIDTH] = lane_y[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            l1          <= 1'b0;
            l2          <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (adv) begin
            v1          <= bus.in_valid;
            l1          <= bus.in_last;
            v2          <= v1;
            l2          <= l1;
            out_valid_q <= v2;
            out_last_q  <= l2;
        end
    end

`ifdef HARD_ACT_SAT_CNT_EN
    logic [16:0] sat_n;
    logic [16:0] sat_sum;

    always_comb begin
        sat_n = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sat_n = sat_n + 17'(lane_sat[i]);
        end
        sat_sum = {1'b0, sat_cnt} + sat_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat_clr ^ (^lane_sat);
    assign sat_cnt    = '0;
`endif
endmodule

// File: tb/tb_hard_act_pipe.sv
// Directed self-checking bench for hard_act_pipe at default parameters (IN 25b, OUT 14b, 4 lanes).
module tb_hard_act_pipe;
    localparam int IW = 25;
    localparam int DW = 14;
`ifdef HARD_ACT_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;
    int          tests = 0;
    int          fails = 0;

    hard_act_if #(.INT_BITS(5), .FRAC_BITS(9), .LANES(4)) bus ();

    hard_act_pipe #(.INT_BITS(5), .FRAC_BITS(9), .LANES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sat_clr (sat_clr),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*IW-1:0] pin(input int a, input int b, input int c, input int d);
        logic [4*IW-1:0] r;
        r[0*IW +: IW] = a[IW-1:0];
        r[1*IW +: IW] = b[IW-1:0];
        r[2*IW +: IW] = c[IW-1:0];
        r[3*IW +: IW] = d[IW-1:0];
        return r;
    endfunction

    function automatic logic [4*DW-1:0] pout(input int a, input int b, input int c, input int d);
        logic [4*DW-1:0] r;
        r[0*DW +: DW] = a[DW-1:0];
        r[1*DW +: DW] = b[DW-1:0];
        r[2*DW +: DW] = c[DW-1:0];
        r[3*DW +: DW] = d[DW-1:0];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] m, input logic [4*IW-1:0] d, input logic last);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_data  = d;
        bus.in_last  = last;
    endtask

    initial begin
        int              in_idx;
        int              out_idx;
        logic            acc;
        logic            stalled_in;
        logic            prev_stall;
        logic [4*DW-1:0] prev_d;
        logic            prev_l;

        drive(1'b0, 2'd0, '0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_sat_cnt", sat_cnt, 16'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", bus.in_ready, 1'b1);

        // ReLU and latency
        drive(1'b1, 2'd0, pin(-5, 20000, 1000, 0), 1'b0);
        step();
        drive(1'b0, 2'd0, '0, 1'b0);
        chk("relu_lat1", bus.out_valid, 1'b0);
        step();
        chk("relu_lat2", bus.out_valid, 1'b0);
        step();
        chk("relu_lat3", bus.out_valid, 1'b1);
        chk("relu_data", bus.out_data, pout(0, 8191, 1000, 0));
        step();
        chk("relu_sat", sat_cnt, SAT_EN ? 16'd1 : 16'd0);
        chk("relu_drained", bus.out_valid, 1'b0);

        // Back-to-back beats with a mode change each beat
        drive(1'b1, 2'd1, pin(4000, 3072, -1, 100), 1'b0);
        step();
        drive(1'b1, 2'd2, pin(0, 1536, -1536, 512), 1'b0);
        step();
        drive(1'b1, 2'd3, pin(512, -768, -2000, 2000), 1'b1);
        step();
        drive(1'b0, 2'd0, '0, 1'b0);
        chk("relu6_data", bus.out_data, pout(3072, 3072, 0, 100));
        chk("relu6_last", bus.out_last, 1'b0);
        step();
        chk("hsig_valid", bus.out_valid, 1'b1);
        chk("hsig_data", bus.out_data, pout(255, 512, 0, 340));
        chk("hsig_last", bus.out_last, 1'b0);
        step();
        chk("hswish_data", bus.out_data, pout(340, -191, 0, 2000));
        chk("hswish_last", bus.out_last, 1'b1);
        step();
        chk("modes_drained", bus.out_valid, 1'b0);
        chk("modes_sat", sat_cnt, SAT_EN ? 16'd2 : 16'd0);

        // Backpressure: out_ready low for 5 cycles while 6 beats are offered
        in_idx     = 0;
        out_idx    = 0;
        stalled_in = 1'b0;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (in_idx < 6)
                drive(1'b1, 2'd0, pin(in_idx*10+1, in_idx*10+2, in_idx*10+3, in_idx*10+4), in_idx == 5);
            else
                drive(1'b0, 2'd0, '0, 1'b0);
            #1;
            if (prev_stall) begin
                chk("bp_hold_data", bus.out_data, prev_d);
                chk("bp_hold_last", bus.out_last, prev_l);
            end
            acc = bus.in_valid && bus.in_ready;
            if (!bus.in_ready) stalled_in = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                chk("bp_data", bus.out_data,
                    pout(out_idx*10+1, out_idx*10+2, out_idx*10+3, out_idx*10+4));
                chk("bp_last", bus.out_last, out_idx == 5);
                out_idx++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            prev_l     = bus.out_last;
            step();
            if (acc) in_idx++;
        end
        drive(1'b0, 2'd0, '0, 1'b0);
        bus.out_ready = 1'b1;
        chk("bp_in_count", in_idx, 6);
        chk("bp_out_count", out_idx, 6);
        chk("bp_ready_dropped", stalled_in, 1'b1);
        step();
        chk("bp_no_extra", bus.out_valid, 1'b0);

        // sat_clr wins over a coincident increment
        drive(1'b1, 2'd0, pin(20000, 20000, -20000, 0), 1'b0);
        step();
        step();
        drive(1'b0, 2'd0, '0, 1'b0);
        step();
        step();
        chk("clr_pre_data", bus.out_data, pout(8191, 8191, 0, 0));
        chk("clr_pre_sat", sat_cnt, SAT_EN ? 16'd4 : 16'd0);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("clr_priority", sat_cnt, 16'd0);

        // Reset mid-stream with sat_clr and an increment on the same edge
        drive(1'b1, 2'd0, pin(20000, 1, 2, 3), 1'b0);
        step();
        step();
        step();
        chk("mid_pre_valid", bus.out_valid, 1'b1);
        rst_n   = 1'b0;
        sat_clr = 1'b1;
        drive(1'b0, 2'd0, '0, 1'b0);
        step();
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_sat", sat_cnt, 16'd0);
        chk("mid_rst_data", bus.out_data, '0);
        rst_n   = 1'b1;
        sat_clr = 1'b0;
        step();
        chk("mid_ready", bus.in_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("mid_flushed", bus.out_valid, 1'b0);
            step();
        end
        chk("mid_final_sat", sat_cnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hard_act_pipe.md
HARD_ACT_PIPE -- requirements
Module: hard_act_pipe

Interface
REQ-001 SHALL have parameter INT_BITS, default 5, integer bits of the output format, sign bit included.
REQ-002 SHALL have parameter FRAC_BITS, default 9, fraction bits of the input and output formats.
REQ-003 SHALL have parameter LANES, default 4, number of parallel channels per beat.
REQ-004 SHALL derive localparams DATA_WIDTH = INT_BITS+FRAC_BITS and IN_WIDTH = 2*DATA_WIDTH-FRAC_BITS+6.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit, beat present.
REQ-008 SHALL have port in_ready, output, 1 bit, beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data, input, LANES*IN_WIDTH bits, signed accumulators; lane i at [i*IN_WIDTH +: IN_WIDTH].
REQ-010 SHALL have port in_mode, input, 2 bits: 0 ReLU, 1 ReLU6, 2 hard-sigmoid, 3 hard-swish.
REQ-011 SHALL have port in_last, input, 1 bit, end-of-tensor sideband.
REQ-012 SHALL have port out_valid, output, 1 bit.
REQ-013 SHALL have port out_ready, input, 1 bit.
REQ-014 SHALL have port out_data, output, LANES*DATA_WIDTH bits, signed results, same lane packing.
REQ-015 SHALL have port out_last, output, 1 bit, in_last delayed with its beat.
REQ-016 SHALL have port sat_clr, input, 1 bit, clears the saturation counter.
REQ-017 SHALL have port sat_cnt, output, 16 bits, saturation event count.

Function
REQ-018 SHALL use constants ONE = 2^FRAC_BITS, THREE = 3*ONE, SIX = 6*ONE, C6 = round(ONE/6) (85 at default), MAXV = 2^(DATA_WIDTH-1)-1, MINV = -2^(DATA_WIDTH-1).
REQ-019 SHALL compute, per lane, xs = x clamped to [MINV, MAXV].
REQ-020 SHALL compute ReLU as 0 if x<0, else min(x, MAXV).
REQ-021 SHALL compute ReLU6 as clamp(x, 0, SIX).
REQ-022 SHALL compute hard-sigmoid: 0 if x<=-THREE; ONE if x>=THREE; else ((x+THREE)*C6)>>FRAC_BITS, truncated.
REQ-023 SHALL compute hard-swish: 0 if x<=-THREE; xs if x>=THREE; else (xs*hsig)>>FRAC_BITS, arithmetic shift (floor).
REQ-024 SHALL be a 3-stage pipeline (S1 clamp/offset, S2 C6 multiply, S3 xs*hsig and mode select), mode and last travelling with the beat; latency exactly 3 cycles with no stall.
REQ-025 SHALL use one global advance: adv = !out_valid || out_ready; in_ready = adv; all stages hold when !adv.
REQ-026 SHALL keep out_data and out_last stable while out_valid && !out_ready.
REQ-027 SHALL apply mode per beat; a mode change between consecutive beats needs no flush.
REQ-028 SHALL count, per beat leaving on out_valid && out_ready, the lanes where a MAXV/SIX/MINV clamp engaged; sat_cnt SHALL stick at 0xFFFF.
REQ-029 SHALL give sat_clr priority over a same-cycle increment; the counter SHALL hold 0 that cycle.

Reset
REQ-030 SHALL, on rst_n low at a clk edge, clear all stage valids, out_valid, out_data, out_last and sat_cnt to 0.
REQ-031 SHALL discard in-flight beats on a reset mid-operation; in_ready SHALL read 1 on the first cycle after reset release.

Configuration
REQ-032 SHALL implement REQ-028/029 only when HARD_ACT_SAT_CNT_EN is defined; otherwise sat_cnt SHALL be tied to 0, sat_clr ignored, and ports unchanged.

Structure
REQ-033 SHALL place mode encodings, ONE/THREE/SIX/C6 derivation and MAXV/MINV in package hard_act_pkg.
REQ-034 SHALL implement the per-lane datapath in sub-module hard_act_lane, instantiated LANES times; handshake and counter stay in hard_act_pipe.

Verification
REQ-035 SHALL cover ReLU with lanes {-5, 20000, 1000, 0}: out {0, 8191, 1000, 0} 3 cycles later, sat_cnt += 1.
REQ-036 SHALL cover ReLU6 with lanes {4000, 3072, -1, 100}: out {3072, 3072, 0, 100}.
REQ-037 SHALL cover hard-sigmoid with lanes {0, 1536, -1536, 512}: out {255, 512, 0, 340}.
REQ-038 SHALL cover hard-swish with lanes {512, -768, -2000, 2000}: out {340, -191, 0, 2000}.
REQ-039 SHALL hold out_ready low 5 cycles with 6 beats offered: in_ready drops, no beat lost or duplicated, order and out_last preserved.
REQ-040 SHALL assert rst_n low mid-stream with sat_clr and increment coincident: out_valid=0 next cycle, sat_cnt=0.
